// File: rtl/c0_sample_seq.sv
// Sequencer in front of the combinational top_c0 core: applies one vector at a time,
// samples the core output after a settle interval and queues results in a small FIFO.
module c0_sample_seq #(
   parameter int unsigned SETTLE = 2,
   parameter int unsigned DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [13:0] in_data,
   output logic [13:0] dut_i,
   input  logic [11:0] dut_o,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] out_data,
   output logic [7:0]  samples
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CountFull = (PW + 1)'(DEPTH);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StDrive = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [7:0]  settle_q, settle_d;
   logic [13:0] dut_i_q;
   logic [7:0]  samples_q;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q, count_d;
   logic [11:0]   mem_q [DEPTH];

   logic accept, push, pop;

   assign in_ready  = (state_q == StIdle) && (count_q < CountFull);
   assign accept    = in_valid && in_ready;
   assign push      = (state_q == StDrive) && (settle_q == 8'd0);
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q] : 12'h000;
   assign dut_i     = dut_i_q;
   assign samples   = samples_q;

   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d  = StDrive;
               settle_d = 8'(SETTLE - 1);
            end
         end
         StDrive: begin
            if (settle_q == 8'd0) begin
               state_d = StIdle;
            end else begin
               settle_d = settle_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A push never meets a full FIFO: accept already required a free slot.
   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + (PW + 1)'(1);
      end else if (!push && pop) begin
         count_d = count_q - (PW + 1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         settle_q  <= 8'd0;
         dut_i_q   <= 14'h0000;
         samples_q <= 8'd0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         count_q  <= count_d;
         if (accept) begin
            dut_i_q <= in_data;
         end
         if (push) begin
            wr_ptr_q  <= wr_ptr_q + PW'(1);
            samples_q <= samples_q + 8'd1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // Storage needs no reset; count gates visibility of every entry.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dut_o;
      end
   end

endmodule

// File: tb/tb_c0_sample_seq.sv
// Randomized and directed bench for c0_sample_seq with a behavioural stand-in for top_c0
// that only presents a valid result once its input has been held long enough.
module tb_c0_sample_seq;

   localparam int unsigned SETTLE = 2;
   localparam int unsigned DEPTH  = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] in_data;
   logic [13:0] dut_i;
   logic [11:0] dut_o;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] out_data;
   logic [7:0]  samples;

   int checks = 0;
   int errors = 0;

   c0_sample_seq #(
      .SETTLE(SETTLE),
      .DEPTH (DEPTH)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .dut_i    (dut_i),
      .dut_o    (dut_o),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .samples  (samples)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] core_f(input logic [13:0] v);
      return v[11:0] ^ 12'h2AA ^ {12{v[13] ^ v[12]}};
   endfunction

   // Stand-in core: output is corrupted until the input has been stable long enough.
   logic [13:0] last_i = 14'h0000;
   int unsigned age = 0;
   always @(posedge clk) begin
      if (dut_i != last_i) begin
         last_i <= dut_i;
         age    <= 1;
      end else if (age < 1000) begin
         age <= age + 1;
      end
   end
   assign dut_o = ((dut_i == last_i) && (age >= SETTLE - 1)) ? core_f(dut_i) : ~core_f(dut_i);

   // Reference model
   logic [11:0] m_q[$];
   bit          m_busy;
   logic [13:0] m_vec;
   logic [13:0] m_dut;
   logic [7:0]  m_samples;
   longint      cyc = 0;
   longint      m_cap_at;
   bit          m_acc, m_cap, m_popped;
   logic [11:0] m_pop_val;

   function automatic bit m_in_ready();
      return !m_busy && (m_q.size() < DEPTH);
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_busy    = 1'b0;
      m_dut     = 14'h0000;
      m_samples = 8'd0;
   endtask

   task automatic tick();
      bit acc, pop, cap;
      @(posedge clk);
      acc = in_valid && m_in_ready();
      pop = out_ready && (m_q.size() != 0);
      cap = m_busy && (cyc == m_cap_at);
      if (pop) m_pop_val = m_q.pop_front();
      if (cap) begin
         m_q.push_back(core_f(m_vec));
         m_samples = m_samples + 8'd1;
         m_busy    = 1'b0;
      end
      if (acc) begin
         m_busy   = 1'b1;
         m_vec    = in_data;
         m_dut    = in_data;
         m_cap_at = cyc + SETTLE;
      end
      m_acc    = acc;
      m_cap    = cap;
      m_popped = pop;
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 14'h0000;
      out_ready = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_values();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 14'h0000;
      out_ready = 1'b0;
      model_reset();
      #3;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000 ||
          samples !== 8'd0 || dut_i !== 14'h0000) begin
         errors++;
         $display("FAIL reset_values: got rdy=%b ov=%b od=%h s=%0d di=%h want 1 0 000 0 0000",
                  in_ready, out_valid, out_data, samples, dut_i);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      do_reset();
      in_valid = 1'b1;
      in_data  = 14'h0000;
      tick();
      in_valid = 1'b0;
      checks++;
      if (dut_i !== 14'h0000 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_accept: got di=%h rdy=%b ov=%b want 0000 0 0", dut_i, in_ready,
                  out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_early: got ov=%b want 0", out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'h2AA || samples !== 8'd1 || in_ready !== 1'b1)
      begin
         errors++;
         $display("FAIL single_result: got ov=%b od=%h s=%0d rdy=%b want 1 2aa 1 1", out_valid,
                  out_data, samples, in_ready);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 12'h000) begin
         errors++;
         $display("FAIL single_pop: got ov=%b od=%h want 0 000", out_valid, out_data);
      end
   endtask

   task automatic test_all_ones();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 14'h3FFF;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 12'hD55) begin
         errors++;
         $display("FAIL all_ones_result: got ov=%b od=%h want 1 d55", out_valid, out_data);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL all_ones_one_cycle: got ov=%b want 0", out_valid);
      end
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [13:0] vecs[5] = '{14'h0123, 14'h1ABC, 14'h2F0F, 14'h3333, 14'h0555};
      logic [11:0] got[$];
      int idx = 0;
      do_reset();
      in_valid = 1'b1;
      in_data  = vecs[0];
      for (int c = 0; c < 30; c++) begin
         tick();
         if (m_acc) idx++;
         if (idx < 5) in_data = vecs[idx];
         else in_valid = 1'b0;
      end
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== core_f(vecs[0])) begin
         errors++;
         $display("FAIL full_stall: got rdy=%b ov=%b od=%h want 0 1 %h", in_ready, out_valid,
                  out_data, core_f(vecs[0]));
      end
      out_ready = 1'b1;
      for (int c = 0; c < 60 && got.size() < 5; c++) begin
         if (out_valid && out_ready) got.push_back(out_data);
         tick();
         if (m_acc) idx++;
         if (idx >= 5) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      checks++;
      if (got.size() != 5) begin
         errors++;
         $display("FAIL drain_count: got %0d results want 5", got.size());
      end
      for (int k = 0; k < 5 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== core_f(vecs[k])) begin
            errors++;
            $display("FAIL drain_order[%0d]: got %h want %h", k, got[k], core_f(vecs[k]));
         end
      end
   endtask

   task automatic test_push_pop();
      logic [13:0] vecs[3] = '{14'h0A0A, 14'h1B1B, 14'h2C2C};
      int idx = 0;
      bit hit = 1'b0;
      do_reset();
      in_valid = 1'b1;
      in_data  = vecs[0];
      for (int c = 0; c < 30 && idx < 3; c++) begin
         tick();
         if (m_acc) idx++;
         if (idx < 3) in_data = vecs[idx];
         else in_valid = 1'b0;
      end
      for (int c = 0; c < 10 && !hit; c++) begin
         out_ready = (m_busy && cyc == m_cap_at);
         hit = out_ready;
         tick();
      end
      out_ready = 1'b0;
      checks++;
      if (!hit || out_valid !== 1'b1 || out_data !== core_f(vecs[1]) || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_pop_head: got hit=%b ov=%b od=%h rdy=%b want 1 1 %h 1", hit,
                  out_valid, out_data, in_ready, core_f(vecs[1]));
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== core_f(vecs[2])) begin
         errors++;
         $display("FAIL push_pop_second: got ov=%b od=%h want 1 %h", out_valid, out_data,
                  core_f(vecs[2]));
      end
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL push_pop_empty: got ov=%b want 0 (count must have stayed 2)", out_valid);
      end
   endtask

   task automatic test_reset();
      do_reset();
      in_valid = 1'b1;
      in_data  = 14'h1111;
      for (int c = 0; c < 40 && !(m_q.size() == 2 && m_busy); c++) begin
         tick();
         in_data = in_data + 14'h0101;
      end
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 12'h000 ||
          samples !== 8'd0 || dut_i !== 14'h0000) begin
         errors++;
         $display("FAIL reset_mid_drive: got rdy=%b ov=%b od=%h s=%0d di=%h want 1 0 000 0 0000",
                  in_ready, out_valid, out_data, samples, dut_i);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (in_ready !== 1'b1 || samples !== 8'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got rdy=%b s=%0d ov=%b want 1 0 0", in_ready, samples,
                  out_valid);
      end
   endtask

   task automatic test_counter_wrap();
      int caps = 0;
      do_reset();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 256 * (SETTLE + 1) + 50 && caps < 256; c++) begin
         in_data = 14'($urandom);
         tick();
         if (m_cap) caps++;
         if (caps == 255) begin
            checks++;
            if (samples !== 8'd255) begin
               errors++;
               $display("FAIL wrap_255: got %0d want 255", samples);
            end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (caps != 256 || samples !== 8'd0) begin
         errors++;
         $display("FAIL wrap_zero: got caps=%0d samples=%0d want 256 0", caps, samples);
      end
      tick();
      tick();
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 600; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = 14'($urandom);
         out_ready = ($urandom_range(0, 3) == 0) ? 1'b0 : (c % 97 < 60);
         checks++;
         if (in_ready !== m_in_ready() || out_valid !== (m_q.size() != 0) ||
             out_data !== ((m_q.size() != 0) ? m_q[0] : 12'h000) || samples !== m_samples ||
             dut_i !== m_dut) begin
            errors++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: got rdy=%b ov=%b od=%h s=%0d di=%h want %b %b %h %0d %h",
                        c, in_ready, out_valid, out_data, samples, dut_i, m_in_ready(),
                        m_q.size() != 0, (m_q.size() != 0) ? m_q[0] : 12'h000, m_samples, m_dut);
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset_values();
      test_single();
      test_all_ones();
      test_backpressure();
      test_push_pop();
      test_reset();
      test_counter_wrap();
      do_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/c0_sample_seq.md
# c0_sample_seq

Sequencing stage directly upstream of `top_c0`. It accepts 14-bit input vectors over a valid/ready handshake and drives each onto the `top_c0` input bus `i`. After a programmable settle interval it samples the 12-bit `top_c0` output `o`. Each captured result is queued in a small FIFO and presented downstream over a second valid/ready handshake, so the purely combinational core can be exercised at a controlled, back-pressured rate.

## Interface
- `SETTLE`, default 2: full cycles `dut_i` is held stable before `dut_o` is sampled; legal 1..255.
- `DEPTH`, default 4: result FIFO depth; power of 2, 2..16.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream vector available.
- `in_ready` output 1: stage can accept a vector.
- `in_data` input 14: vector to apply.
- `dut_i` output 14: registered drive to `top_c0` `i`.
- `dut_o` input 12: from `top_c0` `o`.
- `out_valid` output 1: FIFO non-empty.
- `out_ready` input 1: downstream accepts the head.
- `out_data` output 12: FIFO head result.
- `samples` output 8: count of captured results, wraps 255→0.

## Operation
- FSM states: `IDLE` and `DRIVE`. Reset state is `IDLE`.
- `in_ready` = (state == `IDLE`) && (fifo_count < DEPTH). It is combinational and carries no dependency on `in_valid`.
- Accept is `in_valid && in_ready`. On that edge:
  - `dut_i <= in_data`
  - `settle_cnt <= SETTLE-1`
  - state → `DRIVE`
- In `DRIVE`:
  - If `settle_cnt != 0`: decrement.
  - If `settle_cnt == 0`: push `dut_o` into the FIFO, `samples <= samples+1`, state → `IDLE`.
- `dut_i` holds its last value until the next accept; it is never cleared between vectors.
- Only one vector is in flight at a time. Because accept requires room in the FIFO, a push always finds space, and overflow cannot occur.
- Pop is `out_valid && out_ready`; the FIFO advances to the next entry.
- If a push and a pop occur on the same edge, the count is unchanged and both take effect.
- `out_valid` = fifo_count != 0.
- `out_data` = FIFO head while `out_valid` is high, and 12'h000 when the FIFO is empty.
- FIFO is circular with `$clog2(DEPTH)`-bit read and write pointers that wrap naturally, plus a count register of width `$clog2(DEPTH)+1`.
- Reset asserted mid-operation aborts the in-flight vector and empties the FIFO. No partial result is emitted.

## Timing
- Reset values:
  - `dut_i` = 0
  - `out_valid` = 0
  - `out_data` = 0
  - `samples` = 0
  - `in_ready` = 1 (IDLE, FIFO empty)
- Accept at edge E:
  - `dut_i` is valid from E.
  - Capture happens at edge E + SETTLE.
  - `out_valid` rises in the cycle after that edge: latency is SETTLE+1 cycles from accept to `out_valid`.
- `in_ready` returns high the cycle after capture, if there is room in the FIFO.
- Maximum throughput is one vector per SETTLE+1 cycles.
- `out_valid` can stay high while `DRIVE` is in progress; pops proceed in parallel with settling.
- Once `out_valid` is asserted, `out_data` holds stable until popped. Downstream may stall indefinitely.

## Test plan
- **Reset:** assert `rst_n`=0 mid-`DRIVE` with 2 entries queued → all outputs return to their reset values immediately; `in_ready`=1 after release; `samples`=0.
- **Single vector:** SETTLE=2, `top_c0` attached, `in_data`=14'h0000 → `dut_i`=0; `out_valid` rises 3 cycles after accept with `out_data`=12'h2AA; `samples`=1.
- **All ones:** `in_data`=14'h3FFF, `out_ready`=1 → `out_data`=12'hD55 presented for exactly 1 cycle, then `out_valid`=0.
- **Back-pressure to full:** DEPTH=4, `out_ready`=0, `in_valid` held high with 5 distinct vectors → 4 results queued; `in_ready`=0 while count==4. Raise `out_ready` → results drain in order, the 5th vector is accepted, and no entry is lost or duplicated.
- **Simultaneous push and pop:** count=2 and capture coincides with a pop → count stays 2 and ordering is preserved.
- **Counter wrap:** stream 256 vectors → `samples` reads 0 after the 256th capture; a randomized `in_valid`/`out_ready` run matches the reference-model scoreboard exactly.
